// File: rtl/rr_decode_arbiter.sv
// ---------------------------------------------------------------------------
// rr_decode_arbiter
//   Round-robin arbiter that shares one resource among N requesters. A grant
//   is held until the owner drops its request, the arbiter is disabled, or
//   the owner has held it for MAX_HOLD consecutive cycles. The one-hot grant
//   bus is the registered, decoded form of the grant index and drives the
//   select lines of the shared datapath directly.
//
// Parameters
//   N        number of requesters (2, 4 or 8)
//   IDW      grant index width, log2(N)
//   MAX_HOLD maximum consecutive grant cycles per requester (2..255)
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active low
//   en         arbiter enable; low revokes any grant and keeps the arbiter idle
//   req        request vector, bit i = requester i wants the resource
//   gnt        one-hot grant, registered; all zeros when nothing is granted
//   gnt_id     index of the granted requester, meaningful when gnt_valid=1
//   gnt_valid  a grant is active
//   timeout    one-cycle pulse when a grant is force-released at MAX_HOLD
// ---------------------------------------------------------------------------
module rr_decode_arbiter #(
   parameter int N        = 8,
   parameter int IDW      = 3,
   parameter int MAX_HOLD = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id,
   output logic           gnt_valid,
   output logic           timeout
);

   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] MAX_HOLD_C = HW'(MAX_HOLD);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t         state_reg;
   logic [IDW-1:0] ptr_reg;
   logic [HW-1:0]  hold_cnt_reg;
   logic [IDW-1:0] gnt_id_reg;
   logic           gnt_valid_reg;
   logic           timeout_reg;
   logic [N-1:0]   gnt_reg;

   // hit[j] is the request of the requester j positions after ptr. Because N
   // is a power of two, the IDW-bit addition wraps modulo N for free.
   logic [N-1:0]   hit;
   logic [N-1:0]   pick_onehot;
   logic [IDW-1:0] pick_id;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_rot
         logic [IDW-1:0] idx;
         assign idx     = ptr_reg + IDW'(gi);
         assign hit[gi] = req[idx];
      end
   endgenerate

   // First set bit in rotated order wins: scan from the far end so the
   // smallest offset from ptr is the last (winning) assignment.
   always_comb begin
      pick_id = ptr_reg;
      for (int j = N - 1; j >= 0; j--) begin
         if (hit[j]) begin
            pick_id = ptr_reg + IDW'(j);
         end
      end
   end

   // Decode of the winning index, loaded into gnt_reg alongside gnt_id_reg so
   // the one-hot bus and the index always agree.
   generate
      for (gi = 0; gi < N; gi++) begin : g_dec
         assign pick_onehot[gi] = (pick_id == IDW'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         ptr_reg       <= '0;
         hold_cnt_reg  <= '0;
         gnt_id_reg    <= '0;
         gnt_valid_reg <= 1'b0;
         timeout_reg   <= 1'b0;
         gnt_reg       <= '0;
      end else begin
         timeout_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (en && (|req)) begin
                  gnt_id_reg    <= pick_id;
                  gnt_reg       <= pick_onehot;
                  gnt_valid_reg <= 1'b1;
                  hold_cnt_reg  <= HW'(1);
                  state_reg     <= GRANT;
               end
            end
            GRANT: begin
               if (!en) begin
                  // ptr untouched: the same requester wins when en returns.
                  gnt_valid_reg <= 1'b0;
                  gnt_reg       <= '0;
                  hold_cnt_reg  <= '0;
                  state_reg     <= IDLE;
               end else if (!req[gnt_id_reg]) begin
                  gnt_valid_reg <= 1'b0;
                  gnt_reg       <= '0;
                  hold_cnt_reg  <= '0;
                  ptr_reg       <= gnt_id_reg + IDW'(1);
                  state_reg     <= IDLE;
               end else if (hold_cnt_reg == MAX_HOLD_C) begin
                  gnt_valid_reg <= 1'b0;
                  gnt_reg       <= '0;
                  hold_cnt_reg  <= '0;
                  timeout_reg   <= 1'b1;
                  ptr_reg       <= gnt_id_reg + IDW'(1);
                  state_reg     <= IDLE;
               end else begin
                  hold_cnt_reg  <= hold_cnt_reg + HW'(1);
               end
            end
            default: begin
               state_reg     <= IDLE;
               gnt_valid_reg <= 1'b0;
               gnt_reg       <= '0;
               hold_cnt_reg  <= '0;
            end
         endcase
      end
   end

   assign gnt       = gnt_reg;
   assign gnt_id    = gnt_id_reg;
   assign gnt_valid = gnt_valid_reg;
   assign timeout   = timeout_reg;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_decode_arbiter
//   Directed testbench for rr_decode_arbiter (N=8, MAX_HOLD=16). Each task
//   drives one scenario and compares outputs against hand-computed values.
//   Inputs change and outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_rr_decode_arbiter;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_valid;
   logic       timeout;

   int tests_run = 0;
   int tests_failed = 0;

   rr_decode_arbiter #(
      .N        (8),
      .IDW      (3),
      .MAX_HOLD (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .req       (req),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Grant bus must always be the decode of the grant index.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         assert (gnt == (gnt_valid ? (8'h01 << gnt_id) : 8'h00))
            else $error("invariant gnt=%h gnt_id=%0d gnt_valid=%b", gnt, gnt_id, gnt_valid);
      end
   end

   // Advance one clock and check the decode invariant on the new outputs.
   task automatic tick();
      logic [7:0] inv;
      @(posedge clk);
      #1;
      inv = gnt_valid ? (8'h01 << gnt_id) : 8'h00;
      tests_run++;
      if (gnt !== inv) begin
         tests_failed++;
         $display("FAIL invariant: gnt=%h required %h (gnt_id=%0d gnt_valid=%b)",
                  gnt, inv, gnt_id, gnt_valid);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      en    = 1'b1;
      req   = 8'h00;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en    = 1'b1;
      req   = 8'hFF;
      tick();
      tick();
      tests_run++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0 || gnt_id !== 3'd0) begin
         tests_failed++;
         $display("FAIL reset_state: gnt=%h valid=%b timeout=%b id=%0d required 00/0/0/0",
                  gnt, gnt_valid, timeout, gnt_id);
      end
      rst_n = 1'b1;
      tick();
      tests_run++;
      if (gnt !== 8'h01 || gnt_valid !== 1'b1 || gnt_id !== 3'd0) begin
         tests_failed++;
         $display("FAIL reset_first_grant: gnt=%h id=%0d required 01 id 0", gnt, gnt_id);
      end
      $display("[TB] reset: first grant gnt=%h id=%0d", gnt, gnt_id);
   endtask

   task automatic test_fairness();
      int         id;
      logic [7:0] exp;
      do_reset();
      req = 8'hFF;
      for (int g = 0; g < 9; g++) begin
         id  = g % 8;
         exp = 8'h01 << id;
         for (int c = 1; c <= 3; c++) begin
            tick();
            tests_run++;
            if (gnt !== exp || gnt_id !== 3'(id) || gnt_valid !== 1'b1 || timeout !== 1'b0) begin
               tests_failed++;
               $display("FAIL fairness_grant g%0d c%0d: gnt=%h id=%0d required %h id %0d",
                        g, c, gnt, gnt_id, exp, id);
            end
         end
         req[id] = 1'b0;
         tick();
         tests_run++;
         if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL fairness_gap g%0d: gnt=%h valid=%b required 00/0", g, gnt, gnt_valid);
         end
         req[id] = 1'b1;
         $display("[TB] fairness: grant %0d to id %0d, 3 cycles then gap", g, id);
      end
   endtask

   task automatic test_wrap_skip();
      do_reset();
      req = 8'h20;
      tick();                      // grant id 5
      req = 8'h00;
      tick();                      // release, ptr = 6
      req = 8'b0000_0101;
      tick();
      tests_run++;
      if (gnt !== 8'h01 || gnt_id !== 3'd0) begin
         tests_failed++;
         $display("FAIL wrap_grant: gnt=%h id=%0d required 01 id 0", gnt, gnt_id);
      end
      req = 8'b0000_0100;
      tick();                      // release, ptr = 1
      tests_run++;
      if (gnt !== 8'h00) begin
         tests_failed++;
         $display("FAIL wrap_gap: gnt=%h required 00", gnt);
      end
      tick();
      tests_run++;
      if (gnt !== 8'h04 || gnt_id !== 3'd2) begin
         tests_failed++;
         $display("FAIL skip_grant: gnt=%h id=%0d required 04 id 2", gnt, gnt_id);
      end
      $display("[TB] wrap_skip: ptr 6 -> id 0, then id %0d", gnt_id);
   endtask

   task automatic test_timeout();
      int pulses;
      do_reset();
      req    = 8'h08;
      pulses = 0;
      for (int c = 1; c <= 16; c++) begin
         tick();
         if (timeout === 1'b1) pulses++;
         tests_run++;
         if (gnt !== 8'h08 || gnt_id !== 3'd3) begin
            tests_failed++;
            $display("FAIL timeout_hold c%0d: gnt=%h required 08", c, gnt);
         end
      end
      tick();
      if (timeout === 1'b1) pulses++;
      tests_run++;
      if (gnt !== 8'h00 || timeout !== 1'b1) begin
         tests_failed++;
         $display("FAIL timeout_release: gnt=%h timeout=%b required 00/1", gnt, timeout);
      end
      tick();
      if (timeout === 1'b1) pulses++;
      tests_run++;
      if (gnt !== 8'h08 || gnt_id !== 3'd3 || timeout !== 1'b0) begin
         tests_failed++;
         $display("FAIL timeout_regrant: gnt=%h timeout=%b required 08/0", gnt, timeout);
      end
      tests_run++;
      if (pulses != 1) begin
         tests_failed++;
         $display("FAIL timeout_pulses: got %0d required 1", pulses);
      end
      $display("[TB] timeout: id 3 held 16 cycles, %0d timeout pulse(s), re-granted", pulses);
   endtask

   task automatic test_enable_drop();
      do_reset();
      req = 8'h20;
      tick();
      tests_run++;
      if (gnt !== 8'h20 || gnt_id !== 3'd5) begin
         tests_failed++;
         $display("FAIL en_initial: gnt=%h required 20", gnt);
      end
      req = 8'h60;
      en  = 1'b0;
      tick();
      tests_run++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL en_drop: gnt=%h required 00", gnt);
      end
      tick();
      tests_run++;
      if (gnt !== 8'h00) begin
         tests_failed++;
         $display("FAIL en_idle: gnt=%h required 00", gnt);
      end
      en = 1'b1;
      tick();
      tests_run++;
      if (gnt !== 8'h20 || gnt_id !== 3'd5) begin
         tests_failed++;
         $display("FAIL en_regrant: gnt=%h id=%0d required 20 id 5", gnt, gnt_id);
      end
      $display("[TB] enable_drop: id %0d re-granted after en returns", gnt_id);
   endtask

   task automatic test_reset_mid_grant();
      do_reset();
      req = 8'h04;
      tick();                      // grant id 2
      req = 8'h10;
      tick();                      // release id 2, ptr = 3
      tick();                      // grant id 4
      tests_run++;
      if (gnt !== 8'h10 || gnt_id !== 3'd4) begin
         tests_failed++;
         $display("FAIL midrst_grant: gnt=%h required 10", gnt);
      end
      rst_n = 1'b0;
      tick();
      tests_run++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL midrst_drop: gnt=%h required 00", gnt);
      end
      rst_n = 1'b1;
      req   = 8'h21;               // ptr=0 picks id 0; a stale ptr would pick id 5
      tick();
      tests_run++;
      if (gnt !== 8'h01 || gnt_id !== 3'd0) begin
         tests_failed++;
         $display("FAIL midrst_ptr: gnt=%h id=%0d required 01 id 0", gnt, gnt_id);
      end
      $display("[TB] reset_mid_grant: next grant id %0d", gnt_id);
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      req   = 8'h00;
      test_reset();
      test_fairness();
      test_wrap_skip();
      test_timeout();
      test_enable_drop();
      test_reset_mid_grant();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
